lane_array_serializer: RTL and testbench

//   Takes one packed lane vector (LANES lanes x WIDTH bits, lane i at [WIDTH*i+WIDTH-1:WIDTH*i],
//   the same layout the PACK_ARRAY/UNPACK_ARRAY macros produce) plus a per-lane active mask.

---
 rtl/lane_array_serializer.sv | 168 ++++++++++++++++
 tb/tb_lane_array_serializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_array_serializer.sv
// Lane-vector to beat serializer: LANES x WIDTH in, BEAT_LANES lanes per beat, lowest lanes first; 1-cycle accept-to-beat,
// in_ready low while beats are stalled or pending. Define SER_SKIP_EMPTY_EN to skip beats whose mask slice is all zero.
module lane_array_serializer #(
   parameter  int LANES      = 16,
   parameter  int WIDTH      = 32,
   parameter  int BEAT_LANES = 4,
   localparam int BEATS      = LANES / BEAT_LANES,
   localparam int BIDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*WIDTH-1:0]      in_data,
   input  logic [LANES-1:0]            in_mask,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [BEAT_LANES*WIDTH-1:0] out_data,
   output logic [BEAT_LANES-1:0]       out_mask,
   output logic [BIDX_W-1:0]           out_beat,
   output logic                        out_last,
   output logic                        busy
);

   generate
      if (LANES % BEAT_LANES != 0) begin : g_bad_cfg
         $fatal(1, "lane_array_serializer: LANES must be a multiple of BEAT_LANES");
      end
   endgenerate

   typedef enum logic {IDLE, SEND} state_t;

   state_t                        state, state_d;
   logic [BIDX_W-1:0]             beat_q, beat_d;
   logic                          last_q, last_d;
   logic [LANES*WIDTH-1:0]        held_q, held_d;
   logic [LANES-1:0]              hmask_q, hmask_d;
   logic [BEAT_LANES*WIDTH-1:0]   odata_q, odata_d;
   logic [BEAT_LANES-1:0]         omask_q, omask_d;
   logic [BEATS-1:0]              in_ne, hold_ne;
   logic                          accept;

   function automatic logic [BEAT_LANES*WIDTH-1:0] beat_data(input logic [LANES*WIDTH-1:0] d,
                                                             input logic [LANES-1:0] m,
                                                             input logic [BIDX_W-1:0] b);
      logic [BEAT_LANES*WIDTH-1:0] r;
      r = '0;
      for (int k = 0; k < BEATS; k++) begin
         if (b == BIDX_W'(k)) begin
            for (int j = 0; j < BEAT_LANES; j++) begin
               if (m[k*BEAT_LANES+j]) r[j*WIDTH +: WIDTH] = d[(k*BEAT_LANES+j)*WIDTH +: WIDTH];
            end
         end
      end
      return r;
   endfunction

   function automatic logic [BEAT_LANES-1:0] beat_mask(input logic [LANES-1:0] m,
                                                       input logic [BIDX_W-1:0] b);
      logic [BEAT_LANES-1:0] r;
      r = '0;
      for (int k = 0; k < BEATS; k++) begin
         if (b == BIDX_W'(k)) r = m[k*BEAT_LANES +: BEAT_LANES];
      end
      return r;
   endfunction

   // Lowest beat at or above start that is marked as carrying data.
   function automatic logic [BIDX_W-1:0] first_from(input logic [BEATS-1:0] ne, input int start);
      logic [BIDX_W-1:0] r;
      r = '0;
      for (int k = BEATS - 1; k >= 0; k--) begin
         if (k >= start && ne[k]) r = BIDX_W'(k);
      end
      return r;
   endfunction

   function automatic logic is_last(input logic [BEATS-1:0] ne, input logic [BIDX_W-1:0] b);
      logic r;
      r = 1'b1;
      for (int k = 0; k < BEATS; k++) begin
         if (k > int'(b) && ne[k]) r = 1'b0;
      end
      return r;
   endfunction

`ifdef SER_SKIP_EMPTY_EN
   function automatic logic [BEATS-1:0] nonempty(input logic [LANES-1:0] m);
      logic [BEATS-1:0] r;
      for (int k = 0; k < BEATS; k++) r[k] = |m[k*BEAT_LANES +: BEAT_LANES];
      return r;
   endfunction

   assign in_ne   = nonempty(in_mask);
   assign hold_ne = nonempty(hmask_q);
`else
   assign in_ne   = '1;
   assign hold_ne = '1;
`endif

   assign in_ready = (state == IDLE) || (state == SEND && last_q && out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state;
      beat_d  = beat_q;
      last_d  = last_q;
      held_d  = held_q;
      hmask_d = hmask_q;
      odata_d = odata_q;
      omask_d = omask_q;
      if (accept) begin
         // Covers both IDLE and the final-beat handshake, so vectors follow with no bubble.
         held_d  = in_data;
         hmask_d = in_mask;
         if (|in_ne) begin
            state_d = SEND;
            beat_d  = first_from(in_ne, 0);
            last_d  = is_last(in_ne, beat_d);
            odata_d = beat_data(in_data, in_mask, beat_d);
            omask_d = beat_mask(in_mask, beat_d);
         end else begin
            state_d = IDLE;
            beat_d  = '0;
            last_d  = 1'b0;
         end
      end else if (state == SEND && out_ready) begin
         if (last_q) begin
            state_d = IDLE;
            beat_d  = '0;
            last_d  = 1'b0;
         end else begin
            beat_d  = first_from(hold_ne, int'(beat_q) + 1);
            last_d  = is_last(hold_ne, beat_d);
            odata_d = beat_data(held_q, hmask_q, beat_d);
            omask_d = beat_mask(hmask_q, beat_d);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         beat_q  <= '0;
         last_q  <= 1'b0;
         held_q  <= '0;
         hmask_q <= '0;
         odata_q <= '0;
         omask_q <= '0;
      end else begin
         state   <= state_d;
         beat_q  <= beat_d;
         last_q  <= last_d;
         held_q  <= held_d;
         hmask_q <= hmask_d;
         odata_q <= odata_d;
         omask_q <= omask_d;
      end
   end

   assign out_valid = (state == SEND);
   assign busy      = (state == SEND);
   assign out_beat  = beat_q;
   assign out_last  = last_q;
   assign out_data  = odata_q;
   assign out_mask  = omask_q;

endmodule

// File: tb/tb_lane_array_serializer.sv
// Bench for lane_array_serializer at LANES=4, WIDTH=8, BEAT_LANES=2: directed cases then random traffic
// against a queue of expected beats built from each accepted vector.
module tb_lane_array_serializer;
   localparam int LANES  = 4;
   localparam int WIDTH  = 8;
   localparam int BL     = 2;
   localparam int BEATS  = 2;
   localparam int BIDX_W = 1;
`ifdef SER_SKIP_EMPTY_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct {
      logic [BL*WIDTH-1:0] d;
      logic [BL-1:0]       m;
      logic [BIDX_W-1:0]   b;
      logic                l;
   } beat_t;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*WIDTH-1:0] in_data;
   logic [LANES-1:0]       in_mask;
   logic                   out_valid;
   logic                   out_ready;
   logic [BL*WIDTH-1:0]    out_data;
   logic [BL-1:0]          out_mask;
   logic [BIDX_W-1:0]      out_beat;
   logic                   out_last;
   logic                   busy;

   int    tests = 0;
   int    fails = 0;
   logic  acc   = 1'b0;
   beat_t exp_q[$];

   lane_array_serializer #(.LANES(LANES), .WIDTH(WIDTH), .BEAT_LANES(BL)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
      .out_beat(out_beat), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Every beat the vector should produce, in order; all-zero slices vanish in skip mode.
   task automatic push_model(input logic [LANES*WIDTH-1:0] d, input logic [LANES-1:0] m);
      beat_t e;
      int    n;
      int    lane;
      n = 0;
      for (int b = 0; b < BEATS; b++) begin
         e.d = '0;
         e.m = '0;
         e.b = BIDX_W'(b);
         e.l = 1'b0;
         for (int j = 0; j < BL; j++) begin
            lane = b * BL + j;
            e.m[j] = m[lane];
            if (m[lane]) e.d[j*WIDTH +: WIDTH] = d[lane*WIDTH +: WIDTH];
         end
         if (!SKIP || e.m != '0) begin
            exp_q.push_back(e);
            n++;
         end
      end
      if (n > 0) exp_q[exp_q.size()-1].l = 1'b1;
   endtask

   // Called at a falling edge with inputs already set; returns at the next falling edge.
   task automatic step();
      beat_t e;
      logic  exp_valid;
      logic  exp_ready;
      #1;
      exp_valid = (exp_q.size() != 0);
      exp_ready = !exp_valid || (exp_q.size() == 1 && out_ready);
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      check("busy", {31'd0, busy}, {31'd0, exp_valid});
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      if (exp_valid && out_valid) begin
         e = exp_q[0];
         check("out_data", {16'd0, out_data}, {16'd0, e.d});
         check("out_mask", {30'd0, out_mask}, {30'd0, e.m});
         check("out_beat", {31'd0, out_beat}, {31'd0, e.b});
         check("out_last", {31'd0, out_last}, {31'd0, e.l});
         if (out_ready) e = exp_q.pop_front();
      end
      acc = in_valid && in_ready;
      if (acc) push_model(in_data, in_mask);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int r;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_beat", {31'd0, out_beat}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      rst_n = 1'b1;

      // Basic two-beat vector
      in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_mask = 4'hF; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("t2_b0_data", {16'd0, out_data}, 32'h0000BBAA);
      check("t2_b0_last", {31'd0, out_last}, 32'd0);
      step();
      check("t2_b1_data", {16'd0, out_data}, 32'h0000DDCC);
      check("t2_b1_beat", {31'd0, out_beat}, 32'd1);
      check("t2_b1_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      step();

      // Backpressure on beat 0
      in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_mask = 4'hF; out_ready = 1'b1;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t3_hold_data", {16'd0, out_data}, 32'h0000BBAA);
         check("t3_hold_beat", {31'd0, out_beat}, 32'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      check("t3_b1_data", {16'd0, out_data}, 32'h0000DDCC);
      step();

      // Lane masking
      in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_mask = 4'b0110;
      step();
      in_valid = 1'b0;
      check("t4_b0_data", {16'd0, out_data}, 32'h0000BB00);
      check("t4_b0_mask", {30'd0, out_mask}, 32'd2);
      step();
      check("t4_b1_data", {16'd0, out_data}, 32'h000000CC);
      check("t4_b1_mask", {30'd0, out_mask}, 32'd1);
      step();

      // Back-to-back vectors
      in_valid = 1'b1; in_data = 32'h44332211; in_mask = 4'hF;
      step();
      in_data = 32'h88776655;
      step();
      check("t5_second_accept", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("t5_no_bubble", {31'd0, out_valid}, 32'd1);
      check("t5_b_b0_data", {16'd0, out_data}, 32'h00006655);
      step();
      check("t5_b_b1_data", {16'd0, out_data}, 32'h00008877);
      step();
      step();

      // Empty beats and empty vectors
      in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_mask = 4'b1100;
      step();
      in_valid = 1'b0;
`ifdef SER_SKIP_EMPTY_EN
      check("t6_skip_data", {16'd0, out_data}, 32'h0000DDCC);
      check("t6_skip_beat", {31'd0, out_beat}, 32'd1);
      check("t6_skip_last", {31'd0, out_last}, 32'd1);
      step();
`else
      check("t6_zero_beat_data", {16'd0, out_data}, 32'h00000000);
      check("t6_zero_beat_last", {31'd0, out_last}, 32'd0);
      step();
      check("t6_b1_data", {16'd0, out_data}, 32'h0000DDCC);
      step();
`endif
      in_valid = 1'b1; in_mask = 4'b0000;
      step();
      check("t6_empty_accepted", {31'd0, acc}, 32'd1);
      in_valid = 1'b0;
`ifdef SER_SKIP_EMPTY_EN
      check("t6_empty_no_beat", {31'd0, out_valid}, 32'd0);
      step();
`else
      check("t6_empty_b0", {16'd0, out_data}, 32'h00000000);
      step();
      check("t6_empty_b1_last", {31'd0, out_last}, 32'd1);
      step();
`endif
      step();

      // Reset in the middle of a vector
      in_valid = 1'b1; in_data = 32'h12345678; in_mask = 4'hF; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("t1_mid_out_valid", {31'd0, out_valid}, 32'd0);
      check("t1_mid_busy", {31'd0, busy}, 32'd0);
      check("t1_mid_in_ready", {31'd0, in_ready}, 32'd1);
      check("t1_mid_out_beat", {31'd0, out_beat}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) step();

      // Random traffic with stalls and held offers
      acc = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!in_valid || acc) begin
            if ($urandom_range(0, 2) != 0) begin
               in_valid = 1'b1;
               in_data  = $urandom;
               r        = $urandom_range(0, 3);
               in_mask  = (r == 0) ? 4'h0 : 4'($urandom);
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
      check("drain_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
